// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-through data cache with tree-PLRU replacement,
// line-fill miss handling over a req/ack memory port, bulk flush and hit/miss counters.
module assoc_cache_ctrl #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned WORDS   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  flush,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  busy,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [32*WORDS-1:0]   mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    localparam int unsigned SETS   = 1 << INDEX_W;
    localparam int unsigned WORD_W = $clog2(WORDS);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned LINE_W = 32 * WORDS;

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StFlush} state_e;

    state_e state_q, state_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-2:0]   plru_q  [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [INDEX_W-1:0] flush_ptr_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WORD_W-1:0]  word;
    logic               hit, found_invalid;
    logic [WAY_W-1:0]   hit_way, victim;
    logic [LINE_W-1:0]  hit_line;
    logic               rd_hit, fill_done, wr_done;
    logic               unused_addr_lsb;

    assign idx  = cpu_addr[OFF_W+INDEX_W-1:OFF_W];
    assign tag  = cpu_addr[ADDR_W-1:OFF_W+INDEX_W];
    assign word = cpu_addr[OFF_W-1:2];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // Walk from the root, each node bit selecting the half that holds the victim.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
        int unsigned n;
        n = 0;
        for (int l = 0; l < WAY_W; l++) n = 2 * n + 1 + 32'(t[n]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    // A left child (odd heap index) is the lower half, so its parent must point up.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                   input logic [WAY_W-1:0] w);
        int unsigned n, p;
        logic [WAYS-2:0] r;
        r = t;
        n = 32'(w) + WAYS - 1;
        for (int l = 0; l < WAY_W; l++) begin
            p    = (n - 1) / 2;
            r[p] = n[0];
            n    = p;
        end
        return r;
    endfunction

    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        found_invalid = 1'b0;
        victim        = plru_victim(plru_q[idx]);
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_invalid && !valid_q[idx][w]) begin
                found_invalid = 1'b1;
                victim        = WAY_W'(w);
            end
        end
    end

    assign hit_line  = data_q[idx][hit_way];
    assign rd_hit    = (state_q == StIdle) && !flush && !cpu_wr && cpu_rd && hit;
    assign fill_done = (state_q == StFill) && mem_ack;
    assign wr_done   = (state_q == StWrite) && mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush)                state_d = StFlush;
                else if (cpu_wr)          state_d = StWrite;
                else if (cpu_rd && !hit)  state_d = StFill;
            end
            StFill:  if (mem_ack) state_d = StIdle;
            StWrite: if (mem_ack) state_d = StIdle;
            StFlush: if (flush_ptr_q == INDEX_W'(SETS - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (rd_hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = hit_line[{word, 5'b0} +: 32];
                end
            end
            StFill: begin
                mem_rd_req = 1'b1;
                mem_addr   = {cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    if (cpu_rd) cpu_rdata = mem_rdata[{word, 5'b0} +: 32];
                end
            end
            StWrite: begin
                mem_wr_req = 1'b1;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
                cpu_ready  = mem_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            flush_ptr_q <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            // Pointer wraps back to 0 on the last flushed set, ready for the next sweep.
            if (state_q == StFlush) begin
                valid_q[flush_ptr_q] <= '0;
                plru_q[flush_ptr_q]  <= '0;
                flush_ptr_q          <= flush_ptr_q + 1'b1;
            end
            if (rd_hit) begin
                plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (fill_done) begin
                valid_q[idx][victim] <= 1'b1;
                plru_q[idx]          <= plru_touch(plru_q[idx], victim);
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
            if (wr_done && hit) plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[idx][victim] <= mem_rdata;
            tag_q[idx][victim]  <= tag;
        end
        if (wr_done && hit) data_q[idx][hit_way][{word, 5'b0} +: 32] <= cpu_wdata;
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: read hits/misses, PLRU victim order, write-through,
// flush sweep, reset during a fill and counter saturation on a 4-bit-counter instance.
module tb_assoc_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst, cpu_rd, cpu_wr, flush, mem_ack;
    logic [18:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [63:0] mem_rdata;

    logic [31:0] cpu_rdata, mem_wdata;
    logic        cpu_ready, busy, mem_rd_req, mem_wr_req;
    logic [18:0] mem_addr;
    logic [15:0] hit_cnt, miss_cnt;

    logic [31:0] cpu_rdata4, mem_wdata4;
    logic        cpu_ready4, busy4, mem_rd_req4, mem_wr_req4;
    logic [18:0] mem_addr4;
    logic [3:0]  hit_cnt4, miss_cnt4;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    assoc_cache_ctrl u_dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .flush(flush), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .busy(busy), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    assoc_cache_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .flush(flush), .cpu_rdata(cpu_rdata4), .cpu_ready(cpu_ready4),
        .busy(busy4), .mem_rd_req(mem_rd_req4), .mem_wr_req(mem_wr_req4), .mem_addr(mem_addr4),
        .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_line(input logic [18:0] a);
        logic [31:0] la;
        la = {13'h0, a[18:3], 3'b000};
        return {32'hB000_0000 | la, 32'hA000_0000 | la};
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] line, input logic [18:0] a);
        return a[2] ? line[63:32] : line[31:0];
    endfunction

    task automatic do_read(input logic [18:0] a, input bit exp_hit, input logic [63:0] fill,
                           input logic [31:0] exp_data);
        logic [31:0] e;
        int i;
        sb.push_back(exp_data);
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = a;
        #1;
        if (exp_hit) begin
            exp_hits++;
            check("hit_ready", cpu_ready, 1);
        end else begin
            exp_misses++;
            check("miss_not_ready", cpu_ready, 0);
            i = 0;
            while (!mem_rd_req && i < 20) begin
                @(negedge clk);
                #1;
                i++;
            end
            check("rd_req", mem_rd_req, 1);
            check("rd_addr", mem_addr, {a[18:3], 3'b000});
            mem_ack = 1'b1;
            mem_rdata = fill;
            #1;
            check("fill_ready", cpu_ready, 1);
        end
        e = sb.pop_front();
        check("rdata", cpu_rdata, e);
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic do_write(input logic [18:0] a, input logic [31:0] d);
        int i;
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        #1;
        check("wr_not_ready", cpu_ready, 0);
        i = 0;
        while (!mem_wr_req && i < 20) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("wr_req", mem_wr_req, 1);
        check("wr_addr", mem_addr, a);
        check("wr_data", mem_wdata, d);
        mem_ack = 1'b1;
        #1;
        check("wr_ready", cpu_ready, 1);
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, i;
        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; flush = 1'b0; mem_ack = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", cpu_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_req", mem_rd_req, 0);
        check("rst_wr_req", mem_wr_req, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic miss then same-line hit
        do_read(19'h008, 1'b0, 64'h22222222_11111111, 32'h11111111);
        do_read(19'h00C, 1'b1, '0, 32'h22222222);
        check("cnt_hit_1", hit_cnt, exp_hits);
        check("cnt_miss_1", miss_cnt, exp_misses);

        // Fill set 1 and exercise PLRU replacement
        do_read(19'h208, 1'b0, mk_line(19'h208), word_of(mk_line(19'h208), 19'h208));
        do_read(19'h408, 1'b0, mk_line(19'h408), word_of(mk_line(19'h408), 19'h408));
        do_read(19'h608, 1'b0, mk_line(19'h608), word_of(mk_line(19'h608), 19'h608));
        do_read(19'h008, 1'b1, '0, 32'h11111111);
        do_read(19'h808, 1'b0, mk_line(19'h808), word_of(mk_line(19'h808), 19'h808));
        do_read(19'h408, 1'b0, mk_line(19'h408), word_of(mk_line(19'h408), 19'h408));
        do_read(19'h008, 1'b1, '0, 32'h11111111);
        do_read(19'h60C, 1'b1, '0, word_of(mk_line(19'h608), 19'h60C));
        do_read(19'h808, 1'b1, '0, word_of(mk_line(19'h808), 19'h808));
        do_read(19'h208, 1'b0, mk_line(19'h208), word_of(mk_line(19'h208), 19'h208));
        check("cnt_hit_2", hit_cnt, exp_hits);
        check("cnt_miss_2", miss_cnt, exp_misses);

        // Write-through: hit updates the line, miss does not allocate
        do_write(19'h00C, 32'hDEADBEEF);
        do_read(19'h00C, 1'b1, '0, 32'hDEADBEEF);
        do_read(19'h008, 1'b1, '0, 32'h11111111);
        do_write(19'h0A10, 32'h12345678);
        do_read(19'h0A10, 1'b0, mk_line(19'h0A10), word_of(mk_line(19'h0A10), 19'h0A10));
        check("cnt_hit_3", hit_cnt, exp_hits);
        check("cnt_miss_3", miss_cnt, exp_misses);

        // Flush: busy for exactly one cycle per set, no completions meanwhile
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_pulse_ready", cpu_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        bad = 0;
        while (busy && n < 200) begin
            n++;
            if (cpu_ready) bad++;
            @(posedge clk);
            #1;
        end
        check("flush_busy_cycles", n, 64);
        check("flush_ready_low", bad, 0);
        do_read(19'h008, 1'b0, mk_line(19'h008), word_of(mk_line(19'h008), 19'h008));
        do_read(19'h608, 1'b0, mk_line(19'h608), word_of(mk_line(19'h608), 19'h608));
        do_read(19'h0A10, 1'b0, mk_line(19'h0A10), word_of(mk_line(19'h0A10), 19'h0A10));

        // Reset in the middle of a fill
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = 19'h208;
        i = 0;
        while (!mem_rd_req && i < 20) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("rstfill_rd_req", mem_rd_req, 1);
        @(negedge clk);
        rst = 1'b1;
        cpu_rd = 1'b0;
        #1;
        check("rstfill_req_drop", mem_rd_req, 0);
        check("rstfill_busy_drop", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = mk_line(19'h208);
        #1;
        check("stray_ack_ready", cpu_ready, 0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("stray_ack_busy", busy, 0);
        check("stray_ack_miss_cnt", miss_cnt, 0);
        do_read(19'h208, 1'b0, mk_line(19'h208), word_of(mk_line(19'h208), 19'h208));

        // Counter saturation on the 4-bit instance
        do_read(19'h008, 1'b0, mk_line(19'h008), word_of(mk_line(19'h008), 19'h008));
        for (int k = 0; k < 20; k++)
            do_read(19'h008, 1'b1, '0, word_of(mk_line(19'h008), 19'h008));
        check("cnt_hit_wide", hit_cnt, exp_hits);
        check("cnt_miss_wide", miss_cnt, exp_misses);
        check("cnt4_hit_sat", hit_cnt4, (exp_hits > 15) ? 15 : exp_hits);
        check("cnt4_miss", miss_cnt4, (exp_misses > 15) ? 15 : exp_misses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/assoc_cache_ctrl.md
# assoc_cache_ctrl

Parametrised N-way set-associative data cache with integrated miss-handling controller, sitting between the MEM-stage CPU port and the SRAM/memory controller. Read hits return in the request cycle. Read misses fetch a full line over a req/ack memory port and allocate a victim chosen by tree pseudo-LRU. Writes are write-through, no-allocate, and a bulk flush sweeps all sets; hit and miss statistics counters are provided.

## Interface
- ADDR_W, 19, byte-address width; addresses word aligned (bits [1:0] ignored)
- INDEX_W, 6, set-index bits; SETS = 2^INDEX_W
- WAYS, 4, associativity; legal values 2, 4, 8
- WORDS, 2, 32-bit words per line (power of 2, ≥2); OFF_W = log2(WORDS)+2, TAG_W = ADDR_W-INDEX_W-OFF_W
- CNT_W, 16, statistics counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_rd / cpu_wr  in  1  read / write request; held with addr/data stable until cpu_ready; cpu_wr wins if both high
- cpu_addr  in  ADDR_W  request byte address; tag = [ADDR_W-1:OFF_W+INDEX_W], index = [OFF_W+INDEX_W-1:OFF_W], word = [OFF_W-1:2]
- cpu_wdata  in  32  write data
- flush  in  1  single-cycle pulse: invalidate all lines
- cpu_rdata  out  32  read data, valid when cpu_ready & cpu_rd; 0 otherwise
- cpu_ready  out  1  request completes this cycle
- busy  out  1  high in any state other than IDLE
- mem_rd_req / mem_wr_req  out  1  line fetch / word write request, held until mem_ack
- mem_addr  out  ADDR_W  line-aligned (offset bits 0) for reads; cpu_addr for writes
- mem_wdata  out  32  = cpu_wdata during writes
- mem_rdata  in  32*WORDS  fill line; word k at bits [32k+31:32k]; sampled on mem_ack
- mem_ack  in  1  one-cycle completion; ignored when no request outstanding
- hit_cnt / miss_cnt  out  CNT_W  read hits / read misses completed, saturating at all-ones

## Operation
- Storage per set: WAYS×(valid, tag, WORDS×32 data); WAYS-1 PLRU tree bits.
- Hit: way valid & tag equal. At most one way hits.
- States: IDLE, FILL, WRITE, FLUSH.
- IDLE: flush → FLUSH (priority over requests, request ignored). cpu_wr → WRITE. cpu_rd hit → cpu_ready=1 with word combinationally, PLRU touch of hit way, hit_cnt+1. cpu_rd miss → FILL.
- FILL: mem_rd_req=1. On mem_ack: victim line = mem_rdata, tag written, valid=1, PLRU touch victim; cpu_ready=1, cpu_rdata = selected word of mem_rdata; miss_cnt+1; → IDLE.
- WRITE: mem_wr_req=1. On mem_ack: cpu_ready=1; if hit, replace addressed word in hit way and PLRU touch; miss → no allocation; → IDLE. Writes do not affect counters.
- FLUSH: set pointer 0..SETS-1, one set per cycle: all valid and PLRU bits cleared. After SETS cycles → IDLE. flush ignored outside IDLE.
- Victim: lowest-indexed invalid way; else follow PLRU tree. Tree node 0 is root; bit 0 → victim in lower half, 1 → upper half, recursing by heap indexing (children 2n+1, 2n+2). Touch of way w sets every node on its path to point away from w. WAYS=2 reduces to true LRU.
- Nothing else changes state.

## Timing
- Reset: all valid and PLRU bits 0; state IDLE; cpu_ready, busy, mem_rd_req, mem_wr_req 0; cpu_rdata 0; mem_addr, mem_wdata 0; counters 0.
- Read hit latency 0 cycles (cpu_ready in request cycle). Miss: cpu_ready on the mem_ack cycle. FSM returns to IDLE the next cycle; a still-held request is re-evaluated then.
- Write: cpu_ready on mem_ack cycle; write-through complete at that point.
- Flush: busy for exactly SETS cycles after pulse; cpu_ready 0 throughout.
- Reset mid-FILL/WRITE/FLUSH: request outputs drop immediately (asynchronous); a later mem_ack is ignored.

## Test plan
- Defaults (WAYS=4, WORDS=2). After reset, read 0x008 → mem_rd_req, mem_addr 0x008. Ack with 0x22222222_11111111 → cpu_rdata 0x11111111. Read 0x00C → same-cycle hit 0x22222222. hit_cnt=1, miss_cnt=1.
- Fill 0x008, 0x208, 0x408, 0x608 (ways 0-3, set 1), read 0x008 (hit), then read 0x808 → replaces way 2. Read 0x408 misses; read 0x008 and 0x608 hit.
- Write 0x00C=0xDEADBEEF after line 0x008 cached → mem_wr_req with mem_addr 0x00C. After ack, read 0x00C hits with 0xDEADBEEF. Write 0xA10 (miss) → a later read of 0xA10 misses.
- Fill three lines, pulse flush → busy exactly 64 cycles, cpu_ready 0. Afterwards all three reads miss.
- Assert rst while in FILL before mem_ack → mem_rd_req 0 same cycle, then ack ignored. Read of the same address misses.
- CNT_W=4: 20 read hits → hit_cnt = 15 (saturated), miss_cnt unchanged.
